// File: rtl/pc_redirect_ctrl_if.sv
// Front-end redirect bus between the hazard unit / predictor / ID stage and
// the fetch-PC sequencer.
interface pc_redirect_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             stall_i;
  logic             predreq_i;
  logic             brpred_i;
  logic [31:0]      btpred_i;
  logic             mispred_i;
  logic             jump_i;
  logic [31:0]      jump_target_i;
  logic [31:0]      pc_o;
  logic             pc_valid_o;
  logic             flush_if_o;
  logic             flush_id_o;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport master (
    output stall_i, predreq_i, brpred_i, btpred_i, mispred_i, jump_i, jump_target_i,
    input  pc_o, pc_valid_o, flush_if_o, flush_id_o, br_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  stall_i, predreq_i, brpred_i, btpred_i, mispred_i, jump_i, jump_target_i,
    output pc_o, pc_valid_o, flush_if_o, flush_id_o, br_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: arbitrates mispredict, jump, prediction and sequential
// next-PC sources, defers redirects across stalls and counts predictions.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  pc_redirect_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             flush_if_s, flush_id_s;
  logic             br_inc_s, mis_inc_s;
  logic [31:0]      pc_seq_s, redir_tgt_s;

  assign pc_seq_s    = pc_q + 32'd4;
  assign redir_tgt_s = bus.jump_i ? bus.jump_target_i : bus.btpred_i;

  // Next-state, next-PC, flush and counter-increment decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    flush_if_s = 1'b0;
    flush_id_s = 1'b0;
    br_inc_s   = 1'b0;
    mis_inc_s  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.mispred_i) begin
          pc_d       = bus.btpred_i;
          flush_if_s = 1'b1;
          flush_id_s = 1'b1;
          mis_inc_s  = 1'b1;
          state_d    = ST_RECOVER;
        end else begin
          br_inc_s = bus.predreq_i & ~bus.stall_i;
          if (bus.jump_i || bus.brpred_i) begin
            if (bus.stall_i) begin
              pend_d  = redir_tgt_s;
              state_d = ST_HOLD;
            end else begin
              pc_d       = redir_tgt_s;
              flush_if_s = 1'b1;
            end
          end else if (!bus.stall_i) begin
            pc_d = pc_seq_s;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      ST_HOLD: begin
        // The older pending redirect wins over any new jump/prediction.
        if (bus.mispred_i) begin
          pc_d       = bus.btpred_i;
          pend_d     = 32'h0000_0000;
          flush_if_s = 1'b1;
          flush_id_s = 1'b1;
          mis_inc_s  = 1'b1;
          state_d    = ST_RECOVER;
        end else if (!bus.stall_i) begin
          pc_d       = pend_q;
          flush_if_s = 1'b1;
          state_d    = ST_RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_RECOVER: begin
        if (bus.mispred_i) begin
          pc_d       = bus.btpred_i;
          flush_if_s = 1'b1;
          flush_id_s = 1'b1;
          mis_inc_s  = 1'b1;
          state_d    = ST_RECOVER;
        end else if (!bus.stall_i) begin
          pc_d    = pc_seq_s;
          state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_PC;
        pend_d  = 32'h0000_0000;
      end
    endcase

    pc_valid_d = (state_d != ST_BOOT);

    if (br_inc_s && (br_cnt_q != CNT_MAX)) begin
      br_cnt_d = br_cnt_q + CNT_ONE;
    end else begin
      br_cnt_d = br_cnt_q;
    end

    if (mis_inc_s && (mis_cnt_q != CNT_MAX)) begin
      mis_cnt_d = mis_cnt_q + CNT_ONE;
    end else begin
      mis_cnt_d = mis_cnt_q;
    end
  end

  // State, PC, pending target and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      pend_q     <= 32'h0000_0000;
      br_cnt_q   <= {CNT_W{1'b0}};
      mis_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      pend_q     <= pend_d;
      br_cnt_q   <= br_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pc_valid_o    = pc_valid_q;
  assign bus.flush_if_o    = flush_if_s;
  assign bus.flush_id_o    = flush_id_s;
  assign bus.br_cnt_o      = br_cnt_q;
  assign bus.mispred_cnt_o = mis_cnt_q;

endmodule
